c3_weight_bank: RTL and testbench
=================================

# c3_weight_bank

Stores one C3 output kernel's weights (GP input groups × NW taps) as they are streamed in from the C3 weight demultiplexer's per-kernel write port. Once the set is complete, it replays them to the C3 convolution PE one tap per cycle, all GP group weights in parallel. One instance sits downstream of each of the 16 per-kernel write ports.

## Interface
Parameters:
- WD, 8, weight width in bits
- NW, 25, taps per kernel (5×5)
- GP, 6, input groups (C2 feature maps)

Ports:
- i_sclk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_w_en  in  GP  write group select, one-hot, bit g = group g
- i_w_data  in  WD*GP  packed write data, group g at [g*WD +: WD]
- i_w_addr  in  5  tap address 0..NW-1
- i_clr  in  1  invalidate bank, return to EMPTY (new layer/kernel load)
- i_rd_start  in  1  request one readout pass
- i_rd_stall  in  1  hold current readout tap
- o_full  out  1  all NW*GP weights loaded
- o_rd_valid  out  1  o_rd_addr/o_rd_data valid
- o_rd_addr  out  5  tap index being presented
- o_rd_data  out  WD*GP  weights of tap o_rd_addr, group g at [g*WD +: WD]
- o_rd_last  out  1  high with tap NW-1
- o_err  out  1  sticky load-protocol error (only with C3_WBANK_ERR_EN)

## Operation
- Storage: mem[GP][NW] of WD bits. Contents are not reset.
- States: EMPTY, LOAD, FULL, READ.
- Load counter (0..NW*GP) counts accepted write cycles.
- A write cycle is accepted when i_w_en≠0, i_w_addr<NW, and the state is EMPTY or LOAD. On acceptance, mem[g][i_w_addr] ← slice g for every set bit g.
- Upstream order is group 0 taps 0..24, then group 1, and so on. Storage is address-driven, so order does not affect contents.
- EMPTY → LOAD on the first accepted write.
- LOAD → FULL when the count reaches NW*GP.
- Writes in FULL/READ are ignored; weights stay frozen.
- i_w_addr ≥ NW: write dropped, counter unchanged.
- FULL → READ on i_rd_start. i_rd_start in any other state is ignored, including during READ.
- READ: presents taps 0..NW-1 in order.
  - Each non-stalled cycle advances one tap.
  - After tap NW-1 is accepted (no stall), state → FULL.
  - Passes are repeatable any number of times.
- i_clr, any state: next state EMPTY, count 0, o_full 0, read aborted (o_rd_valid 0). i_clr wins over a same-cycle write or start.
- Multi-hot i_w_en (without the macro): all set groups are written; the counter advances by 1.

## Timing
- Reset: o_full 0, o_rd_valid 0, o_rd_addr 0, o_rd_data 0, o_rd_last 0, o_err 0, state EMPTY, count 0.
- Write latency: data written at edge t is readable in any later pass.
- o_full rises the cycle after the edge that accepts the NW*GP-th write.
- i_rd_start sampled high in FULL at edge t: o_rd_valid=1, o_rd_addr=0, o_rd_data=mem[*][0] from t+1.
- Outputs are registered, one tap per cycle.
- Stall: i_rd_stall high at an edge holds o_rd_addr, o_rd_data, o_rd_last, o_rd_valid unchanged.
- o_rd_last=1 exactly while o_rd_addr=NW-1 and valid.
- Minimum gap between passes is one idle cycle: a start is sampled only in FULL.
- o_rd_data is 0 whenever o_rd_valid=0.

## Configuration
- C3_WBANK_ERR_EN defined:
  - o_err is present.
  - A write cycle with non-one-hot i_w_en, i_w_addr≥NW, or (group, addr) ≠ the expected sequence position (count/NW, count%NW) sets o_err.
  - o_err is sticky and cleared only by i_rst or i_clr.
  - A non-one-hot write is dropped.
- Undefined: no o_err port, no checking logic; behaviour as in Operation.

## Structure
- Shared package c3_pkg holds:
  - WD, NW, GP defaults
  - NW_W=5 (tap address width)
  - CNT_W (width of NW*GP)
  - state enum {EMPTY, LOAD, FULL, READ}
- Sub-module c3_wbank_rdseq holds the read sequencer (tap counter, valid/last, stall hold). The bank module holds the storage, load counter, state and error logic.

## Test plan
- Reset, then 150 in-order writes with data = g*25+addr → o_full rises one cycle after write 150; no o_err.
- Start in FULL → taps 0..24 on consecutive cycles from the next cycle. Tap 7 group 3 = 82. o_rd_last only at tap 24. Two back-to-back passes are identical.
- Stall held 3 cycles at tap 10 → addr 10 and data stable for 4 cycles, then 11; total pass length 28 cycles.
- i_clr asserted at tap 12 of a read → o_rd_valid 0 next cycle, o_full 0. A later start is ignored until a reload completes.
- Writes while FULL with data 0xFF → a subsequent read returns the original values. Write at i_w_addr=30 during load → dropped, count unchanged.
- With C3_WBANK_ERR_EN: i_w_en=6'b000011 → o_err 1 and write dropped. o_err clears on i_clr. Without the macro the same stimulus writes both groups.

Source files
------------

// File: rtl/c3_pkg.sv
// ---------------------------------------------------------------------------
// c3_pkg
// Shared definitions for the C3 weight-bank slice: default geometry of one
// C3 output kernel (weight width, taps, input groups), derived widths and the
// bank state encoding.
// ---------------------------------------------------------------------------
package c3_pkg;

    localparam int WD    = 8;                    // weight width in bits
    localparam int NW    = 25;                   // taps per kernel (5x5)
    localparam int GP    = 6;                    // input groups (C2 maps)
    localparam int NW_W  = 5;                    // tap address width
    localparam int CNT_W = $clog2(NW * GP + 1);  // load counter width

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } wbank_state_e;

endpackage

// File: rtl/c3_wbank_rdseq.sv
// ---------------------------------------------------------------------------
// c3_wbank_rdseq
// Read sequencer of the C3 weight bank. A start pulse launches one pass over
// taps 0..NW-1; every non-stalled cycle advances one tap and the registered
// outputs hold while stalled. The sequencer tells the bank which tap row to
// fetch next and takes that row back combinationally to register it.
//
// Ports:
//   i_sclk        clock, rising edge
//   i_rst         synchronous active-high reset
//   i_clr         abort pass, outputs return to idle
//   i_start       launch a pass (already qualified by the bank state)
//   i_stall       hold the current tap
//   i_tap_data    row for o_fetch_addr, group g at [g*WD +: WD]
//   o_fetch_addr  tap the next registered row is taken from
//   o_done        last tap accepted this cycle
//   o_rd_valid    o_rd_addr/o_rd_data valid
//   o_rd_addr     tap index presented
//   o_rd_data     weights of that tap (zero when not valid)
//   o_rd_last     high with tap NW-1
// ---------------------------------------------------------------------------
import c3_pkg::*;

module c3_wbank_rdseq #(
    parameter int WD   = c3_pkg::WD,
    parameter int NW   = c3_pkg::NW,
    parameter int GP   = c3_pkg::GP,
    parameter int NW_W = c3_pkg::NW_W
) (
    input  logic               i_sclk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic [WD*GP-1:0]   i_tap_data,
    output logic [NW_W-1:0]    o_fetch_addr,
    output logic               o_done,
    output logic               o_rd_valid,
    output logic [NW_W-1:0]    o_rd_addr,
    output logic [WD*GP-1:0]   o_rd_data,
    output logic               o_rd_last
);

    localparam logic [NW_W-1:0] LAST_TAP = NW_W'(NW - 1);

    logic               valid_q, valid_d;
    logic [NW_W-1:0]    addr_q,  addr_d;
    logic [WD*GP-1:0]   data_q,  data_d;
    logic               last_q,  last_d;
    logic               advance;

    assign advance = valid_q && !i_stall;

    // Outside a pass, and on the final tap, the fetch points at tap 0 so a
    // start always loads row 0 and no out-of-range row is ever addressed.
    assign o_fetch_addr = (valid_q && !last_q) ? (addr_q + NW_W'(1)) : '0;
    assign o_done       = advance && last_q && !i_clr;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        if (i_clr) begin
            valid_d = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            last_d  = 1'b0;
        end else if (i_start) begin
            valid_d = 1'b1;
            addr_d  = '0;
            data_d  = i_tap_data;
            last_d  = (NW == 1);
        end else if (advance) begin
            if (last_q) begin
                // Pass complete: drop to idle with data forced to zero.
                valid_d = 1'b0;
                addr_d  = '0;
                data_d  = '0;
                last_d  = 1'b0;
            end else begin
                addr_d  = o_fetch_addr;
                data_d  = i_tap_data;
                last_d  = (o_fetch_addr == LAST_TAP);
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_rd_valid = valid_q;
    assign o_rd_addr  = addr_q;
    assign o_rd_data  = data_q;
    assign o_rd_last  = last_q;

endmodule

// File: rtl/c3_weight_bank.sv
// ---------------------------------------------------------------------------
// c3_weight_bank
// Holds one C3 output kernel's weights (GP groups x NW taps) as they arrive
// from the per-kernel write port, then replays them one tap per cycle with
// all GP group weights side by side. Passes repeat until the bank is cleared.
//
// Optional feature: define C3_WBANK_ERR_EN to add the o_err port and the
// load-protocol checker (non-one-hot enable, address out of range, or a
// write off the expected group/tap sequence). Non-one-hot writes are then
// dropped. Without the macro multi-hot writes update every selected group.
//
// Ports:
//   i_sclk      clock, rising edge
//   i_rst       synchronous active-high reset
//   i_w_en      one-hot write group select
//   i_w_data    packed write data, group g at [g*WD +: WD]
//   i_w_addr    tap address 0..NW-1
//   i_clr       invalidate bank, back to EMPTY
//   i_rd_start  request one readout pass (honoured only when FULL)
//   i_rd_stall  hold the current readout tap
//   o_full      all NW*GP weights loaded
//   o_rd_valid  o_rd_addr/o_rd_data valid
//   o_rd_addr   tap index presented
//   o_rd_data   weights of tap o_rd_addr
//   o_rd_last   high with tap NW-1
//   o_err       sticky load-protocol error (C3_WBANK_ERR_EN only)
// ---------------------------------------------------------------------------
import c3_pkg::*;

module c3_weight_bank #(
    parameter int WD   = c3_pkg::WD,
    parameter int NW   = c3_pkg::NW,
    parameter int GP   = c3_pkg::GP,
    parameter int NW_W = c3_pkg::NW_W
) (
    input  logic               i_sclk,
    input  logic               i_rst,
    input  logic [GP-1:0]      i_w_en,
    input  logic [WD*GP-1:0]   i_w_data,
    input  logic [NW_W-1:0]    i_w_addr,
    input  logic               i_clr,
    input  logic               i_rd_start,
    input  logic               i_rd_stall,
    output logic               o_full,
    output logic               o_rd_valid,
    output logic [NW_W-1:0]    o_rd_addr,
    output logic [WD*GP-1:0]   o_rd_data,
    output logic               o_rd_last
`ifdef C3_WBANK_ERR_EN
    ,
    output logic               o_err
`endif
);

    localparam int              TOTAL    = NW * GP;
    localparam int              CNT_BITS = $clog2(TOTAL + 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(TOTAL);

    wbank_state_e           state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q,   cnt_d;
    logic [WD-1:0]          mem_q [GP][NW];

    logic                   loading;
    logic                   addr_ok;
    logic                   en_ok;
    logic                   wr_accept;
    logic                   rd_start;
    logic                   rd_done;
    logic [NW_W-1:0]        fetch_addr;
    logic [WD*GP-1:0]       fetch_row;

    // -----------------------------------------------------------------------
    // Write qualification
    // -----------------------------------------------------------------------
    assign loading = (state_q == EMPTY) || (state_q == LOAD);
    assign addr_ok = (i_w_addr < NW_W'(NW));

`ifdef C3_WBANK_ERR_EN
    // Exactly one group selected; multi-hot cycles are dropped.
    assign en_ok = (i_w_en != '0) && ((i_w_en & (i_w_en - GP'(1))) == '0);
`else
    assign en_ok = |i_w_en;
`endif

    // Clear beats a same-cycle write; weights are frozen once FULL.
    assign wr_accept = loading && en_ok && addr_ok && !i_clr && !i_rst;
    assign rd_start  = (state_q == FULL) && i_rd_start && !i_clr;

    // -----------------------------------------------------------------------
    // Weight storage
    // -----------------------------------------------------------------------
    // NOTE: the weight array carries no reset; every cell is written before
    // it can be read, and leaving it out keeps it mappable onto plain RAM.
    always_ff @(posedge i_sclk) begin
        if (wr_accept) begin
            for (int g = 0; g < GP; g++) begin
                if (i_w_en[g]) begin
                    mem_q[g][i_w_addr] <= i_w_data[g*WD +: WD];
                end
            end
        end
    end

    // Row for the sequencer: the contents are frozen while reading, so an
    // asynchronous read of the tap it asks for is safe.
    always_comb begin
        fetch_row = '0;
        for (int g = 0; g < GP; g++) begin
            fetch_row[g*WD +: WD] = mem_q[g][fetch_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Bank state and load counter
    // -----------------------------------------------------------------------
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: combinational processes use blocking '=' and assign a default to
    // every output first, so no path through them can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_clr) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY, LOAD: begin
                    if (wr_accept) begin
                        // One count per accepted cycle, even when multi-hot.
                        cnt_d   = cnt_q + CNT_BITS'(1);
                        state_d = (cnt_d == CNT_FULL) ? FULL : LOAD;
                    end
                end
                FULL: begin
                    if (rd_start) state_d = READ;
                end
                READ: begin
                    if (rd_done) state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign o_full = (state_q == FULL) || (state_q == READ);

    // -----------------------------------------------------------------------
    // Load-protocol checker
    // -----------------------------------------------------------------------
`ifdef C3_WBANK_ERR_EN
    localparam int GP_W = (GP > 1) ? $clog2(GP) : 1;

    logic               err_q,     err_d;
    logic [NW_W-1:0]    exp_tap_q, exp_tap_d;
    logic [GP_W-1:0]    exp_grp_q, exp_grp_d;
    logic [GP_W-1:0]    w_grp;
    logic               write_cycle;
    logic               seq_ok;

    always_comb begin
        w_grp = '0;
        for (int g = 0; g < GP; g++) begin
            if (i_w_en[g]) w_grp = GP_W'(g);
        end
    end

    // Expected position tracks the load counter as (count/NW, count%NW).
    assign write_cycle = loading && (i_w_en != '0) && !i_clr;
    assign seq_ok      = (w_grp == exp_grp_q) && (i_w_addr == exp_tap_q);

    always_comb begin
        err_d     = err_q;
        exp_tap_d = exp_tap_q;
        exp_grp_d = exp_grp_q;
        if (i_clr) begin
            err_d     = 1'b0;
            exp_tap_d = '0;
            exp_grp_d = '0;
        end else begin
            if (write_cycle && (!en_ok || !addr_ok || !seq_ok)) begin
                err_d = 1'b1;
            end
            if (wr_accept) begin
                if (exp_tap_q == NW_W'(NW - 1)) begin
                    exp_tap_d = '0;
                    exp_grp_d = exp_grp_q + GP_W'(1);
                end else begin
                    exp_tap_d = exp_tap_q + NW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            err_q     <= 1'b0;
            exp_tap_q <= '0;
            exp_grp_q <= '0;
        end else begin
            err_q     <= err_d;
            exp_tap_q <= exp_tap_d;
            exp_grp_q <= exp_grp_d;
        end
    end

    assign o_err = err_q;
`endif

    // -----------------------------------------------------------------------
    // Read sequencer
    // -----------------------------------------------------------------------
    c3_wbank_rdseq #(
        .WD   (WD),
        .NW   (NW),
        .GP   (GP),
        .NW_W (NW_W)
    ) u_rdseq (
        .i_sclk       (i_sclk),
        .i_rst        (i_rst),
        .i_clr        (i_clr),
        .i_start      (rd_start),
        .i_stall      (i_rd_stall),
        .i_tap_data   (fetch_row),
        .o_fetch_addr (fetch_addr),
        .o_done       (rd_done),
        .o_rd_valid   (o_rd_valid),
        .o_rd_addr    (o_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_last    (o_rd_last)
    );

endmodule

// File: tb/tb_c3_weight_bank.sv
// ---------------------------------------------------------------------------
// tb_c3_weight_bank
// Self-checking bench for c3_weight_bank. A behavioural model (weight array,
// accepted-write count, full flag, current readout tap) predicts every output
// and is compared on each falling edge; directed sequences add hand-computed
// expectations. Build with C3_WBANK_ERR_EN to cover the error checker.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_c3_weight_bank;

    localparam int WD   = 8;
    localparam int NW   = 25;
    localparam int GP   = 6;
    localparam int NW_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [GP-1:0]      w_en;
    logic [WD*GP-1:0]   w_data;
    logic [NW_W-1:0]    w_addr;
    logic               clr;
    logic               rd_start;
    logic               rd_stall;
    logic               full;
    logic               rd_valid;
    logic [NW_W-1:0]    rd_addr;
    logic [WD*GP-1:0]   rd_data;
    logic               rd_last;
`ifdef C3_WBANK_ERR_EN
    logic               err;
`endif

    always #5 clk = ~clk;

    c3_weight_bank dut (
        .i_sclk     (clk),
        .i_rst      (rst),
        .i_w_en     (w_en),
        .i_w_data   (w_data),
        .i_w_addr   (w_addr),
        .i_clr      (clr),
        .i_rd_start (rd_start),
        .i_rd_stall (rd_stall),
        .o_full     (full),
        .o_rd_valid (rd_valid),
        .o_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_last  (rd_last)
`ifdef C3_WBANK_ERR_EN
        ,
        .o_err      (err)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    logic [WD-1:0] m_mem [GP][NW];
    int            m_cnt;
    bit            m_full;
    int            m_tap;     // -1 when no pass is running
    bit            m_err;

    function automatic int low_grp(input logic [GP-1:0] e);
        for (int g = 0; g < GP; g++) if (e[g]) return g;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst || clr) begin
            m_cnt  = 0;
            m_full = 1'b0;
            m_tap  = -1;
            m_err  = 1'b0;
        end else begin
            bit one_hot;
            bit en_ok;
            one_hot = ($countones(w_en) == 1);
`ifdef C3_WBANK_ERR_EN
            en_ok = one_hot;
            if (!m_full && w_en != '0) begin
                if (!one_hot || int'(w_addr) >= NW ||
                    low_grp(w_en) != m_cnt / NW || int'(w_addr) != m_cnt % NW)
                    m_err = 1'b1;
            end
`else
            en_ok = (w_en != '0);
`endif
            if (m_tap >= 0) begin
                if (!rd_stall) m_tap = (m_tap == NW - 1) ? -1 : m_tap + 1;
            end else if (m_full) begin
                if (rd_start) m_tap = 0;
            end else if (en_ok && int'(w_addr) < NW) begin
                for (int g = 0; g < GP; g++)
                    if (w_en[g]) m_mem[g][w_addr] = w_data[g*WD +: WD];
                m_cnt++;
                if (m_cnt == NW * GP) m_full = 1'b1;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [WD*GP-1:0] exp_data;
            bit               exp_valid;
            exp_valid = (m_tap >= 0);
            exp_data  = '0;
            if (exp_valid)
                for (int g = 0; g < GP; g++) exp_data[g*WD +: WD] = m_mem[g][m_tap];
            check("cyc_full", full, m_full);
            check("cyc_rd_valid", rd_valid, exp_valid);
            if (exp_valid) check("cyc_rd_addr", rd_addr, m_tap);
            check("cyc_rd_last", rd_last, exp_valid && m_tap == NW - 1);
            check("cyc_rd_data", rd_data, exp_data);
`ifdef C3_WBANK_ERR_EN
            check("cyc_err", err, m_err);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // -----------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        w_en = '0; w_addr = '0; w_data = '0;
        clr = 1'b0; rd_start = 1'b0; rd_stall = 1'b0;
    endtask

    task automatic wr(input logic [GP-1:0] en, input int addr, input logic [WD*GP-1:0] data);
        w_en = en; w_addr = NW_W'(addr); w_data = data;
        cyc();
        w_en = '0;
    endtask

    // In-order load of value (g*25+addr)^xv. Optionally inserts an
    // out-of-range write and a start request part way through.
    task automatic load_all(input logic [7:0] xv, input bit pokes);
        for (int g = 0; g < GP; g++) begin
            for (int a = 0; a < NW; a++) begin
                logic [7:0] v;
                v = 8'(g * 25 + a) ^ xv;
                if (pokes && g == 4 && a == 0) begin
                    wr(GP'(1), 30, {GP{8'hEE}});
                    rd_start = 1'b1; cyc(); rd_start = 1'b0;
                    check("start_ignored_in_load", rd_valid, 1'b0);
                end
                if (g == GP - 1 && a == NW - 1) check("full_before_last", full, 1'b0);
                wr(GP'(1) << g, a, {GP{v}});
            end
        end
        check("full_after_last", full, 1'b1);
    endtask

    logic [WD*GP-1:0] pass_row [NW];
    int               seq_q[$];
    int               pass_len;
    int               last_cnt;

    task automatic run_pass(input int stall_at, input int stall_len);
        int stalled = 0;
        pass_len = 0; last_cnt = 0; seq_q.delete();
        rd_start = 1'b1; cyc(); rd_start = 1'b0;
        while (rd_valid && pass_len < 100) begin
            seq_q.push_back(int'(rd_addr));
            pass_row[rd_addr] = rd_data;
            if (rd_last) last_cnt++;
            if (int'(rd_addr) == stall_at && stalled < stall_len) begin
                rd_stall = 1'b1; stalled++;
            end else begin
                rd_stall = 1'b0;
            end
            pass_len++;
            cyc();
        end
        rd_stall = 1'b0;
    endtask

    task automatic check_seq(input string name, input int stall_at, input int stall_len);
        int exp_q[$];
        int bad = 0;
        for (int t = 0; t < NW; t++) begin
            exp_q.push_back(t);
            if (t == stall_at) for (int k = 0; k < stall_len; k++) exp_q.push_back(t);
        end
        if (exp_q.size() != seq_q.size()) bad++;
        else for (int i = 0; i < exp_q.size(); i++) if (exp_q[i] != seq_q[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [WD*GP-1:0] p1 [NW];
        int               diff;
        int               n;

        idle_in();
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc(); cyc();
        check("rst_full", full, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", rd_data, 0);
        check("rst_last", rd_last, 1'b0);
`ifdef C3_WBANK_ERR_EN
        check("rst_err", err, 1'b0);
`endif
        rst = 1'b0;
        cyc();

        // In-order load, then plain passes.
        load_all(8'h00, 1'b0);
`ifdef C3_WBANK_ERR_EN
        check("no_err_after_load", err, 1'b0);
`endif
        run_pass(-1, 0);
        check("pass1_len", pass_len, NW);
        check("pass1_last_cnt", last_cnt, 1);
        check_seq("pass1_seq", -1, 0);
        check("tap7_grp3", pass_row[7][3*WD +: WD], 82);
        check("tap24_grp5", pass_row[24][5*WD +: WD], 149);
        for (int t = 0; t < NW; t++) p1[t] = pass_row[t];
        run_pass(-1, 0);
        diff = 0;
        for (int t = 0; t < NW; t++) if (pass_row[t] !== p1[t]) diff++;
        check("pass2_identical", diff, 0);
        check("pass2_len", pass_len, NW);

        // Stall three cycles at tap 10.
        run_pass(10, 3);
        check("stall_pass_len", pass_len, 28);
        n = 0;
        foreach (seq_q[i]) if (seq_q[i] == 10) n++;
        check("stall_tap10_cycles", n, 4);
        check_seq("stall_seq", 10, 3);

        // Clear in the middle of a pass.
        rd_start = 1'b1; cyc(); rd_start = 1'b0;
        n = 0;
        while (rd_addr != NW_W'(12) && n < 40) begin cyc(); n++; end
        check("reached_tap12", rd_addr, 12);
        clr = 1'b1; cyc(); clr = 1'b0;
        check("clr_valid", rd_valid, 1'b0);
        check("clr_full", full, 1'b0);
        rd_start = 1'b1; cyc(); rd_start = 1'b0;
        check("start_ignored_empty", rd_valid, 1'b0);

        // Reload with new data, a dropped addr-30 write and a stray start.
        load_all(8'h5A, 1'b1);

        // Writes while FULL must not disturb the weights.
        wr(GP'(1) << 3, 7, {GP{8'hFF}});
        wr({GP{1'b1}}, 0, {GP{8'hFF}});
        wr(GP'(1), 24, {GP{8'hFF}});
        run_pass(-1, 0);
        check("frozen_tap7_grp3", pass_row[7][3*WD +: WD], 8'h08);
        diff = 0;
        for (int t = 0; t < NW; t++)
            for (int g = 0; g < GP; g++)
                if (pass_row[t][g*WD +: WD] !== (8'(g * 25 + t) ^ 8'h5A)) diff++;
        check("frozen_all_taps", diff, 0);

        // Multi-hot write enable.
        clr = 1'b1; cyc(); clr = 1'b0;
`ifdef C3_WBANK_ERR_EN
        wr(6'b000011, 0, {{(GP-2){8'h00}}, 8'hB2, 8'hA1});
        check("multihot_err", err, 1'b1);
        clr = 1'b1; cyc(); clr = 1'b0;
        check("err_cleared", err, 1'b0);
        load_all(8'h00, 1'b0);
        check("err_after_clean_load", err, 1'b0);
`else
        wr(6'b000011, 0, {{(GP-2){8'h00}}, 8'hB2, 8'hA1});
        for (int g = 0; g < GP; g++)
            for (int a = 0; a < NW; a++)
                if (!(a == 0 && g < 2)) wr(GP'(1) << g, a, {GP{8'(g * 25 + a)}});
        check("multihot_one_count", full, 1'b0);
        wr(GP'(1) << 2, 0, {GP{8'd50}});
        check("multihot_full", full, 1'b1);
        run_pass(-1, 0);
        check("multihot_grp0", pass_row[0][0 +: WD], 8'hA1);
        check("multihot_grp1", pass_row[0][WD +: WD], 8'hB2);
        check("multihot_grp2", pass_row[0][2*WD +: WD], 8'd50);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            clr      = ($urandom_range(0, 999) == 0);
            rd_start = ($urandom_range(0, 3) == 0);
            rd_stall = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 15);
            if (r < 7)       w_en = '0;
            else if (r == 7) w_en = GP'($urandom);
            else             w_en = GP'(1) << $urandom_range(0, GP - 1);
            w_addr = ($urandom_range(0, 7) == 0) ? NW_W'($urandom_range(NW, 31))
                                                 : NW_W'($urandom_range(0, NW - 1));
            w_data = {$urandom, $urandom};
            cyc();
        end
        idle_in();
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
